// File: rtl/usb_pkg.sv
// Shared PID constants, packet/state enums and PID check helper for the USB rx parser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package usb_pkg;

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;

    typedef enum logic [1:0] {
        PKT_NONE  = 2'd0,
        PKT_ACK   = 2'd1,
        PKT_DATA  = 2'd2,
        PKT_OTHER = 2'd3
    } usb_pkt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DISCARD = 2'd3
    } usb_parser_state_e;

    // A PID byte carries its own check nibble: upper nibble is the complement of the lower.
    function automatic logic pid_ok(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction

endpackage

// File: rtl/usb_stream_reg.sv
// One-entry registered valid/ready stage for the forwarded payload byte stream.
// Latency: 1 cycle from load to valid.
// Backpressure: holds data stable while valid && !ready; space tells the producer a load is allowed.
module usb_stream_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       load_last,
    output logic       space,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] data,
    output logic       last
);

    // Room for a new byte when empty or when the current one leaves this cycle.
    assign space = !valid || ready;

    // Entry register: load has priority, otherwise drain on ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= 8'h00;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_byte;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/usb_rx_pkt_parser.sv
// Host-side parser of the device->host packet stream: PID check, DATA toggle tracking, payload forwarding, status.
// Latency: payload 1 cycle through the output register; status 1 cycle after the last byte or timeout.
// Backpressure: in_ready follows the payload stage only while forwarding payload; otherwise always ready.
module usb_rx_pkt_parser
    import usb_pkg::*;
#(
    parameter int MAX_PAYLOAD = 64,
    parameter int TIMEOUT     = 1024,
    parameter int LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic             USB_CLK,
    input  logic             USB_RSTn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    input  logic             in_last,
    input  logic             arm,
    input  logic             toggle_clr,
    output logic             pl_valid,
    input  logic             pl_ready,
    output logic [7:0]       pl_byte,
    output logic             pl_last,
    output logic             st_valid,
    output logic [1:0]       st_type,
    output logic [LEN_W-1:0] st_len,
    output logic             st_pid_err,
    output logic             st_toggle_err,
    output logic             st_len_err,
    output logic             st_timeout,
    output logic             exp_toggle
);

    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PAYLOAD);

    usb_parser_state_e state;
    logic [TO_W-1:0]   to_cnt;
    logic [LEN_W-1:0]  len_cnt;

    // Status of the packet currently being consumed, reported at its last byte.
    usb_pkt_type_e     pkt_type;
    logic              pkt_pid_err;
    logic              pkt_tog_err;
    logic              pkt_len_err;

    logic              pl_space;
    logic              xfer;
    logic              hdr_state;
    logic              pid_chk;
    logic              pid_is_data;
    logic              pid_tog_err;
    logic              good_data;
    usb_pkt_type_e     pid_type;
    logic [LEN_W-1:0]  len_next;
    logic              len_full;
    logic              pl_load;
    logic              flip;

    // Only the payload state is throttled by the output stage.
    assign in_ready = (state == ST_PAYLOAD) ? pl_space : 1'b1;

    // PID decode and per-byte control decisions.
    always_comb begin
        xfer        = in_valid && in_ready;
        hdr_state   = (state == ST_IDLE) || (state == ST_WAIT);
        pid_chk     = pid_ok(in_byte);
        pid_is_data = (in_byte == PID_DATA0) || (in_byte == PID_DATA1);
        pid_tog_err = pid_chk && pid_is_data && ((in_byte == PID_DATA1) != exp_toggle);
        good_data   = pid_chk && pid_is_data && !pid_tog_err;
        pid_type    = PKT_OTHER;
        if (pid_chk) begin
            if (in_byte == PID_ACK) begin
                pid_type = PKT_ACK;
            end else if (pid_is_data) begin
                pid_type = PKT_DATA;
            end
        end
        len_next = len_cnt + LEN_W'(1);
        len_full = (len_next == LEN_MAX);
        pl_load  = (state == ST_PAYLOAD) && xfer;
        // An error-free DATA packet completes either as a bare PID or at its last payload byte.
        flip     = xfer && in_last && ((hdr_state && good_data) || (state == ST_PAYLOAD));
    end

    usb_stream_reg u_pl_reg (
        .clk       (USB_CLK),
        .rst_n     (USB_RSTn),
        .load      (pl_load),
        .load_byte (in_byte),
        .load_last (in_last || len_full),
        .space     (pl_space),
        .valid     (pl_valid),
        .ready     (pl_ready),
        .data      (pl_byte),
        .last      (pl_last)
    );

    // Parser FSM with registered status outputs and toggle tracking.
    always_ff @(posedge USB_CLK or negedge USB_RSTn) begin
        if (!USB_RSTn) begin
            state         <= ST_IDLE;
            to_cnt        <= '0;
            len_cnt       <= '0;
            pkt_type      <= PKT_NONE;
            pkt_pid_err   <= 1'b0;
            pkt_tog_err   <= 1'b0;
            pkt_len_err   <= 1'b0;
            st_valid      <= 1'b0;
            st_type       <= 2'd0;
            st_len        <= '0;
            st_pid_err    <= 1'b0;
            st_toggle_err <= 1'b0;
            st_len_err    <= 1'b0;
            st_timeout    <= 1'b0;
            exp_toggle    <= 1'b0;
        end else begin
            st_valid <= 1'b0;

            // Clear after SETUP beats any completion flip in the same cycle.
            if (toggle_clr) begin
                exp_toggle <= 1'b0;
            end else if (flip) begin
                exp_toggle <= ~exp_toggle;
            end

            case (state)
                ST_IDLE, ST_WAIT: begin
                    if (xfer) begin
                        // PID byte: wins over arm and over an expiring timeout.
                        len_cnt     <= '0;
                        pkt_type    <= pid_type;
                        pkt_pid_err <= !pid_chk;
                        pkt_tog_err <= pid_tog_err;
                        pkt_len_err <= 1'b0;
                        if (in_last) begin
                            st_valid      <= 1'b1;
                            st_type       <= pid_type;
                            st_len        <= '0;
                            st_pid_err    <= !pid_chk;
                            st_toggle_err <= pid_tog_err;
                            st_len_err    <= 1'b0;
                            st_timeout    <= 1'b0;
                            state         <= ST_IDLE;
                        end else if (good_data) begin
                            state <= ST_PAYLOAD;
                        end else begin
                            state <= ST_DISCARD;
                        end
                    end else if (state == ST_IDLE) begin
                        if (arm) begin
                            state  <= ST_WAIT;
                            to_cnt <= '0;
                        end
                    end else if (to_cnt == TO_MAX) begin
                        st_valid      <= 1'b1;
                        st_type       <= PKT_NONE;
                        st_len        <= '0;
                        st_pid_err    <= 1'b0;
                        st_toggle_err <= 1'b0;
                        st_len_err    <= 1'b0;
                        st_timeout    <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                ST_PAYLOAD: begin
                    if (xfer) begin
                        len_cnt <= len_next;
                        if (in_last) begin
                            st_valid      <= 1'b1;
                            st_type       <= PKT_DATA;
                            st_len        <= len_next;
                            st_pid_err    <= 1'b0;
                            st_toggle_err <= 1'b0;
                            st_len_err    <= 1'b0;
                            st_timeout    <= 1'b0;
                            state         <= ST_IDLE;
                        end else if (len_full) begin
                            // Oversized: the forwarded stream was already closed with pl_last.
                            pkt_len_err <= 1'b1;
                            state       <= ST_DISCARD;
                        end
                    end
                end

                ST_DISCARD: begin
                    if (xfer && in_last) begin
                        st_valid      <= 1'b1;
                        st_type       <= pkt_type;
                        st_len        <= len_cnt;
                        st_pid_err    <= pkt_pid_err;
                        st_toggle_err <= pkt_tog_err;
                        st_len_err    <= pkt_len_err;
                        st_timeout    <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_pkt_parser.sv
// Scoreboard bench for usb_rx_pkt_parser with small MAX_PAYLOAD/TIMEOUT.
// Latency: n/a.
// Backpressure: exercised by holding pl_ready low during one payload.
module tb_usb_rx_pkt_parser;

    localparam int MAXP  = 4;
    localparam int TMO   = 16;
    localparam int LW    = $clog2(MAXP + 1);

    typedef struct packed {
        logic [1:0]    t;
        logic [LW-1:0] len;
        logic          pe;
        logic          te;
        logic          le;
        logic          to;
    } st_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready, in_last;
    logic [7:0]    in_byte;
    logic          arm, toggle_clr;
    logic          pl_valid, pl_ready, pl_last;
    logic [7:0]    pl_byte;
    logic          st_valid, st_pid_err, st_toggle_err, st_len_err, st_timeout;
    logic [1:0]    st_type;
    logic [LW-1:0] st_len;
    logic          exp_toggle;

    int checks = 0;
    int errors = 0;

    logic [8:0] pl_q[$];
    st_t        st_q[$];
    logic [8:0] pl_e;
    st_t        st_e;

    usb_rx_pkt_parser #(.MAX_PAYLOAD(MAXP), .TIMEOUT(TMO)) dut (
        .USB_CLK       (clk),
        .USB_RSTn      (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_byte       (in_byte),
        .in_last       (in_last),
        .arm           (arm),
        .toggle_clr    (toggle_clr),
        .pl_valid      (pl_valid),
        .pl_ready      (pl_ready),
        .pl_byte       (pl_byte),
        .pl_last       (pl_last),
        .st_valid      (st_valid),
        .st_type       (st_type),
        .st_len        (st_len),
        .st_pid_err    (st_pid_err),
        .st_toggle_err (st_toggle_err),
        .st_len_err    (st_len_err),
        .st_timeout    (st_timeout),
        .exp_toggle    (exp_toggle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents payload or status.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pl_valid && pl_ready) begin
                if (pl_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pl_unexpected: got %0h expected none", {pl_last, pl_byte});
                end else begin
                    pl_e = pl_q.pop_front();
                    chk("pl_last_byte", {23'd0, pl_last, pl_byte}, {23'd0, pl_e});
                end
            end
            if (st_valid) begin
                if (st_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL st_unexpected: got type %0d len %0d", st_type, st_len);
                end else begin
                    st_e = st_q.pop_front();
                    chk("status", {23'd0, st_type, st_len, st_pid_err, st_toggle_err, st_len_err, st_timeout},
                        {23'd0, st_e});
                end
            end
        end
    end

    // Presents one byte and returns at posedge+1 after it transferred.
    task automatic send(input logic [7:0] b, input logic last);
        logic r;
        int   n;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        n = 0;
        forever begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: byte %0h not accepted", b);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(posedge clk);
        #1;
        arm = 1'b0;
    endtask

    task automatic pulse_clr();
        toggle_clr = 1'b1;
        @(posedge clk);
        #1;
        toggle_clr = 1'b0;
    endtask

    function automatic st_t mk(input logic [1:0] t, input int len, input logic pe, input logic te,
                               input logic le, input logic to);
        st_t s;
        s.t = t; s.len = LW'(len); s.pe = pe; s.te = te; s.le = le; s.to = to;
        return s;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        in_valid = 0; in_byte = 0; in_last = 0; arm = 0; toggle_clr = 0; pl_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_pl_valid", {31'd0, pl_valid}, 0);
        chk("rst_st_valid", {31'd0, st_valid}, 0);
        chk("rst_exp_toggle", {31'd0, exp_toggle}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ACK after arm
        pulse_arm();
        chk("wait_in_ready", {31'd0, in_ready}, 1);
        st_q.push_back(mk(2'd1, 0, 0, 0, 0, 0));
        send(8'hD2, 1);
        chk("ack_st_valid", {31'd0, st_valid}, 1);
        chk("ack_toggle", {31'd0, exp_toggle}, 0);

        // DATA0 with 3 bytes, then DATA1 with 1 byte
        pl_q.push_back(9'h011); pl_q.push_back(9'h022); pl_q.push_back(9'h133);
        st_q.push_back(mk(2'd2, 3, 0, 0, 0, 0));
        send(8'hC3, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 1);
        chk("data0_toggle", {31'd0, exp_toggle}, 1);
        pl_q.push_back(9'h1AA);
        st_q.push_back(mk(2'd2, 1, 0, 0, 0, 0));
        send(8'h4B, 0); send(8'hAA, 1);
        chk("data1_toggle", {31'd0, exp_toggle}, 0);

        // zero-length DATA0 flips toggle, then mismatched DATA0
        st_q.push_back(mk(2'd2, 0, 0, 0, 0, 0));
        send(8'hC3, 1);
        chk("zlp_toggle", {31'd0, exp_toggle}, 1);
        st_q.push_back(mk(2'd2, 0, 0, 1, 0, 0));
        send(8'hC3, 0); send(8'h55, 0); send(8'h66, 1);
        chk("togerr_toggle", {31'd0, exp_toggle}, 1);
        pulse_clr();
        chk("clr_toggle", {31'd0, exp_toggle}, 0);

        // corrupted PID
        st_q.push_back(mk(2'd3, 0, 1, 0, 0, 0));
        send(8'hC4, 0); send(8'h01, 1);
        chk("piderr_toggle", {31'd0, exp_toggle}, 0);

        // oversize payload
        pl_q.push_back(9'h001); pl_q.push_back(9'h002); pl_q.push_back(9'h003); pl_q.push_back(9'h104);
        st_q.push_back(mk(2'd2, 4, 0, 0, 1, 0));
        send(8'hC3, 0);
        for (int i = 1; i <= 6; i++) send(8'(i), (i == 6));
        chk("lenerr_toggle", {31'd0, exp_toggle}, 0);

        // timeout exactly TMO cycles after arm
        st_q.push_back(mk(2'd0, 0, 0, 0, 0, 1));
        pulse_arm();
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            k = i;
            if (st_valid) break;
            @(posedge clk);
            #1;
        end
        chk("timeout_cycles", k, TMO + 1);

        // backpressure during payload
        pl_ready = 1'b0;
        pl_q.push_back(9'h077); pl_q.push_back(9'h088); pl_q.push_back(9'h199);
        st_q.push_back(mk(2'd2, 3, 0, 0, 0, 0));
        fork
            begin
                send(8'hC3, 0); send(8'h77, 0); send(8'h88, 0); send(8'h99, 1);
            end
            begin
                int n;
                n = 0;
                while (!pl_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_pl_valid", {31'd0, pl_valid}, 1);
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_in_ready", {31'd0, in_ready}, 0);
                    chk("bp_pl_byte", {24'd0, pl_byte}, 32'h77);
                end
                @(posedge clk);
                #1;
                pl_ready = 1'b1;
            end
        join
        chk("bp_toggle", {31'd0, exp_toggle}, 1);

        repeat (5) @(posedge clk);
        #1;
        chk("pl_q_empty", pl_q.size(), 0);
        chk("st_q_empty", st_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
